// File: rtl/seg_pkg.sv
// seg_pkg: shared widths and types for the seven-segment scan path.
// Used by seg_scan_ctrl and by the downstream hex-to-segment decoder.
package seg_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int SEL_W      = 3;
    localparam int NIB_W      = 4;

    typedef logic [NIB_W-1:0] nibble_t;
    typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/refresh_prescaler.sv
// refresh_prescaler: counts 0..REFRESH_DIV-1 while enable is high.
// Ports: clk, rst_n, enable in; tick out (combinational terminal count).
module refresh_prescaler #(
    parameter int REFRESH_DIV = 100_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);

    localparam int PW =
        (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(REFRESH_DIV - 1);

    logic [PW-1:0] pcnt;

    // High during the last cycle of a slot; the owner
    // registers it so it lines up with the select advance.
    assign tick = enable && (pcnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else if (enable) begin
            pcnt <= pcnt + PW'(1);
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 8-digit time-multiplexed scan controller with digit store.
// Ports: clk, rst_n, enable, wr_*, load_*, blank_mask in; digit, select, blank, tick, frame_done out.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [3:0]  wr_data,
    input  logic        load_all,
    input  logic [31:0] load_data,
    input  logic [7:0]  blank_mask,
    output logic [3:0]  digit,
    output logic [2:0]  select,
    output logic        blank,
    output logic        tick,
    output logic        frame_done
);

    logic    adv;
    sel_t    sel_q;
    sel_t    sel_nx;
    nibble_t mem [NUM_DIGITS];

    refresh_prescaler #(
        .REFRESH_DIV(REFRESH_DIV)
    ) u_pre (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .tick   (adv)
    );

    assign sel_nx = adv ? sel_q + sel_t'(1) : sel_q;
    assign select = sel_q;

    // Outputs look up the slot being entered, so select,
    // digit and blank all change on the same edge. mem is
    // read before this edge's write lands (no bypass).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q      <= '0;
            digit      <= '0;
            blank      <= 1'b1;
            tick       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            sel_q      <= sel_nx;
            digit      <= mem[sel_nx];
            blank      <= blank_mask[sel_nx];
            tick       <= adv;
            frame_done <= adv && (sel_q == sel_t'(NUM_DIGITS - 1));
        end
    end

    // Bulk load takes priority over a single-digit write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                mem[k] <= '0;
            end
        end else if (load_all) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                mem[k] <= load_data[NIB_W*k +: NIB_W];
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl, REFRESH_DIV=4.
// Expected {digit,select,blank,tick,frame_done} queued per edge, popped after it.
module tb_seg_scan_ctrl;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [3:0]  wr_data = '0;
    logic        load_all = 1'b0;
    logic [31:0] load_data = '0;
    logic [7:0]  blank_mask = '0;
    logic [3:0]  digit;
    logic [2:0]  select;
    logic        blank;
    logic        tick;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    logic [9:0] obs;
    logic [9:0] e;
    logic [9:0] q [$];

    int         m_pcnt;
    logic [2:0] m_sel;
    logic [3:0] m_mem [8];

    assign obs = {digit, select, blank, tick, frame_done};

    seg_scan_ctrl #(.REFRESH_DIV(DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .load_all   (load_all),
        .load_data  (load_data),
        .blank_mask (blank_mask),
        .digit      (digit),
        .select     (select),
        .blank      (blank),
        .tick       (tick),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        q.delete();
        m_pcnt = 0;
        m_sel  = '0;
        for (int k = 0; k < 8; k++) m_mem[k] = '0;
    endtask

    // Predict the outputs of the coming edge from the current
    // inputs, queue them, then advance to just after the edge.
    task automatic cyc();
        logic       adv;
        logic [2:0] ns;
        adv = enable && (m_pcnt == DIV - 1);
        ns  = adv ? m_sel + 3'd1 : m_sel;
        q.push_back({m_mem[ns], ns, blank_mask[ns], adv,
                     adv && (m_sel == 3'd7)});
        if (adv) m_pcnt = 0;
        else if (enable) m_pcnt = m_pcnt + 1;
        m_sel = ns;
        if (load_all) begin
            for (int k = 0; k < 8; k++)
                m_mem[k] = load_data[4*k +: 4];
        end else if (wr_en) begin
            m_mem[wr_addr] = wr_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 10'b0000_000_1_0_0) begin
            errors++;
            $display("FAIL reset_async: got %b exp %b",
                     obs, 10'b0000_000_1_0_0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        enable     = 1'b1;
        blank_mask = 8'h00;
        for (int i = 0; i < DIV; i++) begin
            cyc();
            e = q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL reset_run: got %b exp %b", obs, e);
            end
            checks++;
            if (tick !== (i == DIV - 1)) begin
                errors++;
                $display("FAIL reset_first_tick: cyc %0d tick %b",
                         i + 1, tick);
            end
        end
    endtask

    task automatic test_scan();
        logic [31:0] pat;
        int          fd;
        pat       = 32'h89AB_CDEF;
        fd        = 0;
        load_all  = 1'b1;
        load_data = pat;
        cyc();
        load_all = 1'b0;
        e = q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL scan_load: got %b exp %b", obs, e);
        end
        for (int i = 0; i < 16 * DIV; i++) begin
            cyc();
            e = q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL scan: got %b exp %b", obs, e);
            end
            checks++;
            if (digit !== pat[4*select +: 4]) begin
                errors++;
                $display("FAIL scan_digit: sel %0d got %h exp %h",
                         select, digit, pat[4*select +: 4]);
            end
            if (frame_done) fd++;
        end
        checks++;
        if (fd != 2) begin
            errors++;
            $display("FAIL scan_frames: got %0d exp 2", fd);
        end
    endtask

    task automatic test_write();
        int n;
        n = 0;
        while (!(m_sel == 3'd3 && m_pcnt == 0) && n < 64) begin
            cyc();
            e = q.pop_front();
            n++;
        end
        checks++;
        if (n >= 64) begin
            errors++;
            $display("FAIL write_wait: timeout");
        end
        wr_en   = 1'b1;
        wr_addr = 3'd3;
        wr_data = 4'h5;
        cyc();
        wr_en = 1'b0;
        e = q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL write_edge: got %b exp %b", obs, e);
        end
        cyc();
        e = q.pop_front();
        checks++;
        if (digit !== 4'h5 || select !== 3'd3) begin
            errors++;
            $display("FAIL write_digit: got %h/%0d exp 5/3",
                     digit, select);
        end
        for (int i = 0; i < 2 * 8 * DIV; i++) begin
            cyc();
            e = q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL write_run: got %b exp %b", obs, e);
            end
        end
    endtask

    task automatic test_collision();
        load_all  = 1'b1;
        load_data = 32'h1111_1111;
        wr_en     = 1'b1;
        wr_addr   = 3'd2;
        wr_data   = 4'h7;
        cyc();
        load_all = 1'b0;
        wr_en    = 1'b0;
        e = q.pop_front();
        for (int i = 0; i < 8 * DIV; i++) begin
            cyc();
            e = q.pop_front();
            checks++;
            if (obs !== e || digit !== 4'h1) begin
                errors++;
                $display("FAIL collision: got %b exp %b", obs, e);
            end
        end
    endtask

    task automatic test_freeze();
        logic [2:0] held;
        int         n;
        n = 0;
        while (m_pcnt != 2 && n < 16) begin
            cyc();
            e = q.pop_front();
            n++;
        end
        held   = m_sel;
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            e = q.pop_front();
            checks++;
            if (obs !== e || tick !== 1'b0 || select !== held) begin
                errors++;
                $display("FAIL freeze: got %b exp %b", obs, e);
            end
        end
        enable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            e = q.pop_front();
            checks++;
            if (obs !== e || tick !== (i == 1)) begin
                errors++;
                $display("FAIL freeze_resume: cyc %0d got %b exp %b",
                         i + 1, obs, e);
            end
        end
    endtask

    task automatic test_blank();
        blank_mask = 8'h0F;
        for (int i = 0; i < 9 * DIV; i++) begin
            cyc();
            e = q.pop_front();
            if (i == 0) continue;
            checks++;
            if (obs !== e || blank !== (select < 3'd4)) begin
                errors++;
                $display("FAIL blank: sel %0d got %b exp %b",
                         select, obs, e);
            end
        end
        blank_mask = 8'h00;
    endtask

    task automatic test_reset_midscan();
        int n;
        n = 0;
        while (!(m_sel == 3'd5 && m_pcnt == 1) && n < 64) begin
            cyc();
            e = q.pop_front();
            n++;
        end
        checks++;
        if (select !== 3'd5) begin
            errors++;
            $display("FAIL midscan_pre: got %0d exp 5", select);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 10'b0000_000_1_0_0) begin
            errors++;
            $display("FAIL midscan_async: got %b exp %b",
                     obs, 10'b0000_000_1_0_0);
        end
        #1 rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < DIV + 1; i++) begin
            cyc();
            e = q.pop_front();
            checks++;
            if (obs !== e || tick !== (i == DIV - 1)) begin
                errors++;
                $display("FAIL midscan_run: cyc %0d got %b exp %b",
                         i + 1, obs, e);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_scan();
        test_write();
        test_collision();
        test_freeze();
        test_blank();
        test_reset_midscan();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
